// File: rtl/para.sv
// rtl/para.sv - shared network parameters, monitor FSM states and widths
package para;

   localparam int FLIT_SIZE = 32;
   localparam int UTIL_W    = 8;
   localparam int SUM_W     = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      REPORT  = 2'd2
   } mon_state_t;

endpackage

// File: rtl/link_util_monitor_util_counter.sv
// rtl/link_util_monitor_util_counter.sv - windowed busy counter with saturating 8-bit scaled output
module util_counter
   import para::*;
#(
   parameter int WINDOW_LOG2 = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              measure,
   input  logic              inc,
   input  logic              latch,
   input  logic              clr,
   output logic [UTIL_W-1:0] util
);

   logic [WINDOW_LOG2:0] count;
   logic [WINDOW_LOG2:0] count_nxt;
   logic [UTIL_W-1:0]    util_scaled;

   assign count_nxt = count + {{WINDOW_LOG2{1'b0}}, inc};

   // A completely busy window overflows the top slice, so pin it to full scale.
   assign util_scaled = count_nxt[WINDOW_LOG2] ? {UTIL_W{1'b1}}
                                               : count_nxt[WINDOW_LOG2-1 -: UTIL_W];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
         util  <= '0;
      end else begin
         count <= (measure && !latch) ? count_nxt : '0;
         if (clr)
            util <= '0;
         else if (latch)
            util <= util_scaled;
      end
   end

endmodule

// File: rtl/link_util_monitor.sv
// rtl/link_util_monitor.sv - passive link tap reporting per-window direction/injection utilisation
module link_util_monitor
   import para::*;
#(
   parameter int WINDOW_LOG2 = 8,
   parameter int DIR_BIT     = 0,
   parameter int INJ_BIT     = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [FLIT_SIZE:0] link_flit,
   input  logic               en,
   input  logic               clr,
   output logic [UTIL_W-1:0]  cw_util,
   output logic [UTIL_W-1:0]  ccw_util,
   output logic [UTIL_W-1:0]  inj_util,
   output logic [SUM_W-1:0]   link_sum,
   output logic               util_valid,
   output logic               measuring
);

   localparam logic [WINDOW_LOG2-1:0] WIN_ONE = 1;
   localparam logic [SUM_W-1:0]       SUM_ONE = 1;

   mon_state_t             state;
   mon_state_t             state_nxt;
   logic [WINDOW_LOG2-1:0] window_cnt;
   logic                   report_now;
   logic                   in_measure;
   logic                   busy;

   assign in_measure = (state == MEASURE);
   assign busy       = link_flit[FLIT_SIZE];
   assign measuring  = in_measure;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // report_now marks the final counted cycle; outputs land on the following edge.
   always_comb begin
      state_nxt  = state;
      report_now = 1'b0;
      case (state)
         IDLE: begin
            if (en)
               state_nxt = MEASURE;
         end
         MEASURE: begin
            if (!en) begin
               state_nxt = IDLE;
            end else if (window_cnt == {WINDOW_LOG2{1'b1}}) begin
               state_nxt  = REPORT;
               report_now = 1'b1;
            end
         end
         REPORT: begin
            state_nxt = en ? MEASURE : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         window_cnt <= '0;
         util_valid <= 1'b0;
         link_sum   <= '0;
      end else begin
         window_cnt <= in_measure ? window_cnt + WIN_ONE : '0;
         util_valid <= report_now;
         // Cumulative count survives window aborts; only clr or reset clears it.
         if (clr)
            link_sum <= '0;
         else if (in_measure && busy && (link_sum != {SUM_W{1'b1}}))
            link_sum <= link_sum + SUM_ONE;
      end
   end

   util_counter #(.WINDOW_LOG2(WINDOW_LOG2)) u_cw (
      .clk     (clk),
      .rst     (rst),
      .measure (in_measure),
      .inc     (busy && link_flit[DIR_BIT]),
      .latch   (report_now),
      .clr     (clr),
      .util    (cw_util)
   );

   util_counter #(.WINDOW_LOG2(WINDOW_LOG2)) u_ccw (
      .clk     (clk),
      .rst     (rst),
      .measure (in_measure),
      .inc     (busy && !link_flit[DIR_BIT]),
      .latch   (report_now),
      .clr     (clr),
      .util    (ccw_util)
   );

   util_counter #(.WINDOW_LOG2(WINDOW_LOG2)) u_inj (
      .clk     (clk),
      .rst     (rst),
      .measure (in_measure),
      .inc     (busy && link_flit[INJ_BIT]),
      .latch   (report_now),
      .clr     (clr),
      .util    (inj_util)
   );

endmodule

// File: tb/tb_link_util_monitor.sv
// tb/tb_link_util_monitor.sv - randomized window-level checks of link_util_monitor
module tb_link_util_monitor;
   import para::*;

   localparam int WL  = 8;
   localparam int WIN = 1 << WL;
   localparam int DB  = 0;
   localparam int IB  = 1;

   logic               clk = 1'b0;
   logic               rst;
   logic [FLIT_SIZE:0] link_flit;
   logic               en;
   logic               clr;
   logic [UTIL_W-1:0]  cw_util;
   logic [UTIL_W-1:0]  ccw_util;
   logic [UTIL_W-1:0]  inj_util;
   logic [SUM_W-1:0]   link_sum;
   logic               util_valid;
   logic               measuring;

   int vectors     = 0;
   int miscompares = 0;
   int exp_cw      = 0;
   int exp_ccw     = 0;
   int exp_inj     = 0;
   int exp_sum     = 0;

   link_util_monitor #(.WINDOW_LOG2(WL), .DIR_BIT(DB), .INJ_BIT(IB)) dut (
      .clk        (clk),
      .rst        (rst),
      .link_flit  (link_flit),
      .en         (en),
      .clr        (clr),
      .cw_util    (cw_util),
      .ccw_util   (ccw_util),
      .inj_util   (inj_util),
      .link_sum   (link_sum),
      .util_valid (util_valid),
      .measuring  (measuring)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int scale(input int n);
      int s;
      s = n >> (WL - 8);
      return (s > 255) ? 255 : s;
   endfunction

   function automatic logic [FLIT_SIZE:0] gen(input int mode, input int i);
      logic [FLIT_SIZE:0] f;
      logic v, d, j;
      f = {1'b0, 32'($urandom())};
      d = 1'($urandom());
      j = 1'($urandom());
      case (mode)
         1:       begin v = (i % 4 == 0); d = 1'b1; j = 1'b0; end
         2:       begin v = 1'b1; d = 1'b0; j = 1'b1; end
         3:       begin v = 1'b0; d = 1'b1; j = 1'b1; end
         4:       v = 1'b1;
         5:       v = (i % 2 == 0);
         default: v = 1'($urandom());
      endcase
      f[FLIT_SIZE] = v;
      f[DB]        = d;
      f[IB]        = j;
      return f;
   endfunction

   task automatic check_outputs(input string tag, input int valid_exp, input int meas_exp);
      chk({tag, ".util_valid"}, int'(util_valid), valid_exp);
      chk({tag, ".cw_util"},    int'(cw_util),    exp_cw);
      chk({tag, ".ccw_util"},   int'(ccw_util),   exp_ccw);
      chk({tag, ".inj_util"},   int'(inj_util),   exp_inj);
      chk({tag, ".link_sum"},   int'(link_sum),   exp_sum);
      chk({tag, ".measuring"},  int'(measuring),  meas_exp);
   endtask

   // Entry cycle (IDLE or REPORT) carries a fully set valid flit that must not be counted.
   task automatic run_window(input int mode, input int abort_at, input int clr_at, input bit do_reset);
      int n_cw, n_ccw, n_inj;
      bit bad;
      bit v;
      en        = 1'b1;
      clr       = 1'b0;
      link_flit = '1;
      tick();
      n_cw = 0; n_ccw = 0; n_inj = 0; bad = 1'b0;
      for (int i = 0; i < WIN; i++) begin
         if (measuring !== 1'b1 || util_valid !== 1'b0)
            bad = 1'b1;
         link_flit = gen(mode, i);
         if (i == abort_at) begin
            if (do_reset) begin
               #2 rst = 1'b0;
               en = 1'b0;
               #1;
               exp_cw = 0; exp_ccw = 0; exp_inj = 0; exp_sum = 0;
               check_outputs("async_reset", 0, 0);
               tick();
               tick();
               rst = 1'b1;
               tick();
               check_outputs("post_reset", 0, 0);
            end else begin
               link_flit[FLIT_SIZE] = 1'b0;
               en = 1'b0;
               tick();
               check_outputs("abort", 0, 0);
               link_flit = '1;
               tick();
               check_outputs("abort_idle", 0, 0);
            end
            chk("abort.no_early_valid", int'(bad), 0);
            return;
         end
         clr = (i == clr_at);
         v   = link_flit[FLIT_SIZE];
         if (v) begin
            if (link_flit[DB]) n_cw++; else n_ccw++;
            if (link_flit[IB]) n_inj++;
         end
         if (clr) begin
            exp_sum = 0;
            exp_cw = 0; exp_ccw = 0; exp_inj = 0;
         end else if (v && exp_sum < 65535) begin
            exp_sum++;
         end
         tick();
         if (clr && i != WIN - 1) begin
            clr = 1'b0;
            chk("clr.cw_util",  int'(cw_util),  0);
            chk("clr.link_sum", int'(link_sum), 0);
         end
         clr = 1'b0;
      end
      chk("no_early_valid", int'(bad), 0);
      if (clr_at != WIN - 1) begin
         exp_cw  = scale(n_cw);
         exp_ccw = scale(n_ccw);
         exp_inj = scale(n_inj);
      end
      check_outputs("window", 1, 0);
   endtask

   initial begin
      rst       = 1'b0;
      en        = 1'b0;
      clr       = 1'b0;
      link_flit = '1;
      tick();
      tick();
      check_outputs("reset", 0, 0);
      rst = 1'b1;
      tick();
      check_outputs("idle", 0, 0);

      run_window(1, -1, -1, 1'b0);
      chk("cw64.value", int'(cw_util), 64);
      run_window(1, -1, -1, 1'b0);
      run_window(2, -1, -1, 1'b0);
      chk("full.ccw_sat", int'(ccw_util), 255);
      chk("full.inj_sat", int'(inj_util), 255);
      run_window(3, -1, -1, 1'b0);
      for (int k = 0; k < 3; k++)
         run_window(0, -1, -1, 1'b0);
      run_window(5, 200, -1, 1'b0);
      run_window(0, -1, -1, 1'b0);
      run_window(5, 100, -1, 1'b1);
      run_window(0, -1, -1, 1'b0);

      for (int k = 0; k < 257; k++)
         run_window(4, -1, -1, 1'b0);
      chk("sum.saturated", int'(link_sum), 65535);
      run_window(4, -1, 50, 1'b0);
      run_window(0, -1, WIN - 1, 1'b0);

      en = 1'b0;
      link_flit = '1;
      tick();
      check_outputs("final_idle", 0, 0);
      tick();
      check_outputs("final_hold", 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/link_util_monitor.md
Name: link_util_monitor

Overview:
- Passive per-port monitor sitting directly downstream of a node's serial output port (out_<dir>_ser); taps the flit bus without altering it.
- Counts busy cycles over a fixed power-of-two window, split by clockwise / counter-clockwise ring direction and injected-vs-forwarded traffic.
- Reports the three 8-bit utilisations consumed by the network-level summation logic (ClockwiseUtil, CounterClockwiseUtil, InjectUtil), plus a saturating 16-bit cumulative busy count.

Parameters:
- WINDOW_LOG2, 8, log2 of the measurement window in cycles; legal range 8..15.
- DIR_BIT, 0, flit bit index carrying ring direction; 1 = clockwise, 0 = counter-clockwise.
- INJ_BIT, 1, flit bit index set when the flit was injected at this node this hop.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- link_flit  in  FLIT_SIZE+1  tapped serial link; bit FLIT_SIZE is valid.
- en  in  1  measurement enable.
- clr  in  1  synchronous clear of reported values and cumulative count.
- cw_util  out  8  clockwise utilisation of last completed window.
- ccw_util  out  8  counter-clockwise utilisation of last completed window.
- inj_util  out  8  injected-flit utilisation of last completed window.
- link_sum  out  16  cumulative busy cycles since reset/clr; saturates at 16'hFFFF.
- util_valid  out  1  one-cycle pulse when the outputs update.
- measuring  out  1  high while in the MEASURE state.

Behaviour:
- Reset (rst=0, async): state IDLE; every output 0; window counter and all three cycle counters 0.
- Busy cycle: link_flit[FLIT_SIZE]=1. Clockwise when DIR_BIT=1, else counter-clockwise. Injected counter increments independently when INJ_BIT=1. A flit with valid=0 is ignored regardless of its other bits.
- FSM:
  - IDLE: measuring=0; on en=1 go to MEASURE with window_cnt=0 and counters=0. The flit in that same cycle is not counted.
  - MEASURE: measuring=1; each cycle window_cnt++ and the matching counters are updated.
    - Last cycle is window_cnt = 2^WINDOW_LOG2-1, and that cycle's flit is counted. The next cycle is REPORT.
    - en=0 in any cycle aborts: return to IDLE, discard partial counts, outputs unchanged, no util_valid.
  - REPORT (1 cycle): latch the three utils, pulse util_valid=1, zero the counters.
    - en=1 -> MEASURE (a new window starts the next cycle); en=0 -> IDLE.
    - Any flit present in the REPORT cycle is not counted (1-cycle dead time per window).
- Counters are WINDOW_LOG2+1 bits wide (max 2^WINDOW_LOG2).
- util = count[WINDOW_LOG2-1 : WINDOW_LOG2-8]; if count = 2^WINDOW_LOG2 then util = 8'd255 (saturate).
- link_sum:
  - Increments on every busy cycle while in MEASURE, independent of window abort.
  - Holds at 16'hFFFF once reached.
- clr=1:
  - Zeroes cw/ccw/inj_util and link_sum next cycle.
  - Does not affect the FSM or the in-progress window.
  - If clr coincides with REPORT, clr wins: outputs become 0, but util_valid still pulses.
- Latency: utils are visible at the clock edge after the last window cycle, coincident with util_valid.
- The monitor never drives link_flit; there is no backpressure.

Decomposition:
- Shared package para.sv (existing) supplies FLIT_SIZE.
- Add to para.sv:
  - the FSM state typedef (IDLE, MEASURE, REPORT);
  - UTIL_W=8 and SUM_W=16 constants.
- One natural sub-module: util_counter (windowed counter with saturating scale-to-8-bit output), instantiated three times for cw, ccw and inj.
- The FSM and link_sum stay in the top.

Test Plan:
- Reset mid-window: assert rst low at cycle 100 of a window with 50 busy cycles -> all outputs 0 immediately, FSM IDLE, no util_valid.
- WINDOW_LOG2=8, en held 1, 64 clockwise valid flits (no INJ) per window -> util_valid every 257 cycles; cw_util=64, ccw_util=0, inj_util=0; link_sum=64 after the first window.
- Link fully busy with counter-clockwise flits and INJ_BIT=1 for a full window -> ccw_util=255, inj_util=255 (saturated at 256), cw_util=0.
- Invalid flits (valid=0) with DIR=1 and INJ=1 for a full window -> all utils 0, link_sum unchanged, util_valid still pulses.
- en dropped at cycle 200 after 100 busy cycles -> FSM IDLE, utils keep their previous window values, no util_valid, link_sum increased by 100.
- link_sum preloaded near saturation by running long busy traffic past 65535 cycles -> holds 16'hFFFF. Then clr=1 for one cycle -> link_sum=0 and utils=0; the measurement continues uninterrupted.
